// File: rtl/mc_integrator.sv
// mc_integrator: time-multiplexed multi-channel signed integrator (wrap / saturate / integrate-and-dump)
// Ports: clk, resetb (async active-low); in_valid/in_ch/in sample stream; mode, dump_len, clr/clr_ch controls;
//        out_valid/out_ch/out/out_acc/ovf registered result (held when idle); sat_stky per-channel sticky overflow.
module mc_integrator #(
  parameter int IN_W = 9,
  parameter int ACC_W = 26,
  parameter int OUT_W = 9,
  parameter int NCH = 4,
  parameter int CNT_W = 16,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] dump_len,
  input  logic             clr,
  input  logic [CH_W-1:0]  clr_ch,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [OUT_W-1:0] out,
  output logic [ACC_W-1:0] out_acc,
  output logic             ovf,
  output logic [NCH-1:0]   sat_stky
);
  localparam logic [CH_W:0] NCH_L = (CH_W+1)'(NCH);
  logic [ACC_W-1:0] acc_q [NCH];
  logic [ACC_W-1:0] acc_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   sat_stky_q, sat_stky_d;
  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic             ovf_q, ovf_d;
  logic             hit, clr_hit, ovf_w, sat_mode, dump_mode, dump;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] res;
  logic [CNT_W:0]   cnt_inc, dlen;
  assign hit       = in_valid && ({1'b0, in_ch} < NCH_L);
  assign clr_hit   = clr && ({1'b0, clr_ch} < NCH_L);
  assign sum       = {acc_q[in_ch][ACC_W-1], acc_q[in_ch]} + {{(ACC_W+1-IN_W){in[IN_W-1]}}, in};
  assign ovf_w     = sum[ACC_W] ^ sum[ACC_W-1];
  assign sat_mode  = (mode == 2'd1) || (mode == 2'd2);
  assign dump_mode = mode == 2'd2;
  // clamp toward the true sign of the sum, held in the extra top bit
  assign res       = (ovf_w && sat_mode) ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
  assign cnt_inc   = {1'b0, cnt_q[in_ch]} + (CNT_W+1)'(1);
  assign dlen      = {1'b0, (dump_len == '0) ? CNT_W'(1) : dump_len};
  assign dump      = cnt_inc >= dlen;
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_stky_d  = sat_stky_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_acc_d   = out_acc_q;
    ovf_d       = ovf_q;
    if (hit && clr_hit && clr_ch == in_ch) begin
      out_valid_d = 1'b1;
      out_ch_d    = in_ch;
      out_acc_d   = '0;
      ovf_d       = 1'b0;
    end else if (hit) begin
      acc_d[in_ch] = (dump_mode && dump) ? '0 : res;
      cnt_d[in_ch] = (dump_mode && !dump) ? cnt_inc[CNT_W-1:0] : '0;
      if (ovf_w) sat_stky_d[in_ch] = 1'b1;
      if (!dump_mode || dump) begin
        out_valid_d = 1'b1;
        out_ch_d    = in_ch;
        out_acc_d   = res;
        ovf_d       = ovf_w;
      end
    end
    // applied last so a clear always beats a same-channel update
    if (clr_hit) begin
      acc_d[clr_ch]      = '0;
      cnt_d[clr_ch]      = '0;
      sat_stky_d[clr_ch] = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      acc_q       <= '{default: '0};
      cnt_q       <= '{default: '0};
      sat_stky_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_acc_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_stky_q  <= sat_stky_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_acc_q   <= out_acc_d;
      ovf_q       <= ovf_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_acc   = out_acc_q;
  assign out       = out_acc_q[ACC_W-1 -: OUT_W];
  assign ovf       = ovf_q;
  assign sat_stky  = sat_stky_q;
endmodule

// File: tb/tb_mc_integrator.sv
// tb_mc_integrator: scoreboard bench driving a default-width and a 12-bit-accumulator instance in parallel
module tb_mc_integrator;
  logic clk = 0, resetb = 0, in_valid = 0, clr = 0;
  logic [1:0] in_ch = 0, clr_ch = 0, mode = 0;
  logic [8:0] in_s = 0;
  logic [15:0] dump_len = 0;
  logic ov0, ovf0, ov1, ovf1;
  logic [1:0] och0, och1;
  logic [8:0] o0, o1;
  logic [25:0] oacc0;
  logic [11:0] oacc1;
  logic [3:0] stk0, stk1;
  always #5 clk = ~clk;
  mc_integrator u_big (
    .clk(clk), .resetb(resetb), .in_valid(in_valid), .in_ch(in_ch), .in(in_s), .mode(mode),
    .dump_len(dump_len), .clr(clr), .clr_ch(clr_ch), .out_valid(ov0), .out_ch(och0), .out(o0),
    .out_acc(oacc0), .ovf(ovf0), .sat_stky(stk0));
  mc_integrator #(.ACC_W(12)) u_small (
    .clk(clk), .resetb(resetb), .in_valid(in_valid), .in_ch(in_ch), .in(in_s), .mode(mode),
    .dump_len(dump_len), .clr(clr), .clr_ch(clr_ch), .out_valid(ov1), .out_ch(och1), .out(o1),
    .out_acc(oacc1), .ovf(ovf1), .sat_stky(stk1));
  typedef struct {int ch; longint acc; bit ovf; logic [3:0] stky;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  longint macc[2][4];
  int mcnt[2][4];
  logic [3:0] mstky[2];
  int n_chk = 0, n_fail = 0;
  function automatic void chk(string n, logic signed [63:0] a, logic signed [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction
  function automatic void reset_model();
    for (int k = 0; k < 2; k++) begin
      mstky[k] = '0;
      for (int c = 0; c < 4; c++) begin
        macc[k][c] = 0;
        mcnt[k][c] = 0;
      end
    end
  endfunction
  function automatic void step(int k, bit v, int ch, int val, bit c, int cc);
    int aw, dl;
    longint maxv, minv, sum;
    bit o, push, dump;
    exp_t e;
    aw = k ? 12 : 26;
    maxv = (longint'(1) << (aw - 1)) - 1;
    minv = -maxv - 1;
    push = 0;
    e.ch = ch;
    e.acc = 0;
    e.ovf = 0;
    if (v) begin
      if (c && cc == ch) push = 1;
      else begin
        sum = macc[k][ch] + val;
        o = (sum > maxv) || (sum < minv);
        if (mode == 1 || mode == 2) sum = (sum > maxv) ? maxv : (sum < minv) ? minv : sum;
        else if (sum > maxv) sum -= longint'(1) << aw;
        else if (sum < minv) sum += longint'(1) << aw;
        if (o) mstky[k][ch] = 1'b1;
        dl = (dump_len == 0) ? 1 : int'(dump_len);
        dump = mcnt[k][ch] + 1 >= dl;
        if (mode == 2) begin
          macc[k][ch] = dump ? 0 : sum;
          mcnt[k][ch] = dump ? 0 : mcnt[k][ch] + 1;
          push = dump;
        end else begin
          macc[k][ch] = sum;
          mcnt[k][ch] = 0;
          push = 1;
        end
        e.acc = sum;
        e.ovf = o;
      end
    end
    if (c) begin
      macc[k][cc] = 0;
      mcnt[k][cc] = 0;
      mstky[k][cc] = 1'b0;
    end
    if (push) begin
      e.stky = mstky[k];
      if (k == 1) q1.push_back(e);
      else q0.push_back(e);
    end
  endfunction
  task automatic send(input bit v, input int ch, input int val, input bit c = 0, input int cc = 0);
    in_valid = v;
    in_ch = ch[1:0];
    in_s = val[8:0];
    clr = c;
    clr_ch = cc[1:0];
    step(0, v, ch, val, c, cc);
    step(1, v, ch, val, c, cc);
    @(posedge clk);
    #1;
    in_valid = 0;
    clr = 0;
  endtask
  task automatic rep(input int ch, input int val, input int n);
    for (int i = 0; i < n; i++) send(1, ch, val);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (resetb && ov0) begin
      if (q0.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL big_unexpected_valid: got out_valid=1 ch=%0d expected none", och0);
      end else begin
        e = q0.pop_front();
        chk("big_ch", och0, e.ch);
        chk("big_acc", $signed(oacc0), e.acc);
        chk("big_out", $signed(o0), e.acc >>> 17);
        chk("big_ovf", ovf0, e.ovf);
        chk("big_stky", stk0, e.stky);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (resetb && ov1) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL small_unexpected_valid: got out_valid=1 ch=%0d expected none", och1);
      end else begin
        e = q1.pop_front();
        chk("small_ch", och1, e.ch);
        chk("small_acc", $signed(oacc1), e.acc);
        chk("small_out", $signed(o1), e.acc >>> 3);
        chk("small_ovf", ovf1, e.ovf);
        chk("small_stky", stk1, e.stky);
      end
    end
  end
  task automatic check_reset_state(input string tag);
    chk({tag, "_ov0"}, ov0, 0);
    chk({tag, "_out0"}, o0, 0);
    chk({tag, "_acc0"}, oacc0, 0);
    chk({tag, "_stk0"}, stk0, 0);
    chk({tag, "_ov1"}, ov1, 0);
    chk({tag, "_out1"}, o1, 0);
    chk({tag, "_acc1"}, oacc1, 0);
    chk({tag, "_stk1"}, stk1, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_model();
    #1;
    check_reset_state("rst");
    #8 resetb = 1;
    @(posedge clk);
    #1;
    mode = 0;
    rep(0, 255, 513);
    rep(0, 1, 257);
    send(0, 0, 0, 1, 0);
    rep(1, 255, 9);
    send(0, 0, 0, 1, 1);
    mode = 1;
    rep(1, 255, 9);
    rep(1, -256, 20);
    send(0, 0, 0, 1, 1);
    mode = 0;
    for (int i = 0; i < 10; i++) send(1, i % 2, (i % 2) ? -100 : 100);
    mode = 2;
    dump_len = 4;
    rep(3, 5, 12);
    dump_len = 0;
    rep(3, 5, 3);
    mode = 0;
    rep(2, 100, 3);
    send(1, 2, 50, 1, 2);
    send(1, 2, 7);
    send(1, 0, 9, 1, 2);
    send(1, 2, 1);
    mode = 3;
    send(1, 1, 100);
    rep(1, -256, 9);
    send(1, 0, 3);
    #1 resetb = 0;
    #1;
    check_reset_state("async_rst");
    q0.delete();
    q1.delete();
    reset_model();
    #3 resetb = 1;
    mode = 0;
    send(1, 0, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("big_drain", q0.size(), 0);
    chk("small_drain", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
